// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use interlock, branch flush,
// data-memory wait with timeout, and saturating stall/flush/wait event counters.
module hazard_ctrl #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int CNT_WIDTH        = 16,
    parameter int MEM_TIMEOUT      = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
    input  logic                        id_use_rs1,
    input  logic                        id_use_rs2,
    input  logic                        ex_memRead,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
    input  logic                        mem_branch_taken,
    input  logic                        mem_req,
    input  logic                        mem_ready,
    output logic                        pc_write,
    output logic                        if_id_write,
    output logic                        if_id_flush,
    output logic                        id_ex_doNOP,
    output logic                        ex_mem_flush,
    output logic                        pipe_hold,
    output logic                        mem_timeout_err,
    output logic [CNT_WIDTH-1:0]        stall_cnt,
    output logic [CNT_WIDTH-1:0]        flush_cnt,
    output logic [CNT_WIDTH-1:0]        wait_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR_DRAIN} state_t;

    localparam logic [7:0]           TIMEOUT_V = MEM_TIMEOUT[7:0];
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [7:0]           r_timer;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic [CNT_WIDTH-1:0] r_wait_cnt;

    logic       w_load_use;
    logic       w_mem_stall;
    logic       w_stall_evt;
    logic       w_flush_evt;
    logic       w_wait_evt;
    logic [7:0] w_timer_next;

    assign w_load_use = ex_memRead && (ex_rd != '0) &&
                        ((id_use_rs1 && (ex_rd == id_rs1)) ||
                         (id_use_rs2 && (ex_rd == id_rs2)));
    assign w_mem_stall  = mem_req && !mem_ready;
    assign w_timer_next = r_timer + 8'd1;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_doNOP  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_hold    = 1'b0;
        w_stall_evt  = 1'b0;
        w_flush_evt  = 1'b0;
        w_wait_evt   = 1'b0;

        // RUN and a completing MEM_WAIT share the branch/load-use priority chain
        if ((r_state == ERR_DRAIN) || (r_state == MEM_WAIT && !mem_ready) ||
            (r_state == RUN && w_mem_stall)) begin
            if (r_state == ERR_DRAIN) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_doNOP  = 1'b1;
                ex_mem_flush = 1'b1;
            end else begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_hold   = 1'b1;
                w_wait_evt  = 1'b1;
            end
        end else if (mem_branch_taken) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_doNOP  = 1'b1;
            ex_mem_flush = 1'b1;
            w_flush_evt  = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_doNOP = 1'b1;
            w_stall_evt = 1'b1;
        end

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_doNOP  = 1'b1;
            ex_mem_flush = 1'b0;
            pipe_hold    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_timer     <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state <= MEM_WAIT;
                        r_timer <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end else begin
                        r_timer <= w_timer_next;
                        if (w_timer_next >= TIMEOUT_V) begin
                            r_err   <= 1'b1;
                            r_state <= ERR_DRAIN;
                        end
                    end
                end
                default: r_state <= RUN;
            endcase

            if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
            if (w_wait_evt  && (r_wait_cnt  != '1)) r_wait_cnt  <= r_wait_cnt  + CNT_ONE;
        end
    end

    assign mem_timeout_err = r_err;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;
    assign wait_cnt        = r_wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expected control vectors are
// queued with the stimulus and compared mid-cycle against the DUT outputs.
module tb_hazard_ctrl;

    localparam int CW = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_doNOP, ex_mem_flush, pipe_hold}
    localparam logic [5:0] C_NORM  = 6'b110000;
    localparam logic [5:0] C_HOLD  = 6'b000001;
    localparam logic [5:0] C_BR    = 6'b101110;
    localparam logic [5:0] C_LU    = 6'b000100;
    localparam logic [5:0] C_DRAIN = 6'b001110;
    localparam logic [5:0] C_RST   = 6'b000100;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_memRead;
    logic          mem_branch_taken, mem_req, mem_ready;
    logic          pc_write, if_id_write, if_id_flush, id_ex_doNOP, ex_mem_flush, pipe_hold;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [5:0] exp_q[$];

    hazard_ctrl #(.REG_NUM_BITWIDTH(5), .CNT_WIDTH(CW), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_doNOP(id_ex_doNOP), .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold),
        .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [5:0] ctrl();
        return {pc_write, if_id_write, if_id_flush, id_ex_doNOP, ex_mem_flush, pipe_hold};
    endfunction

    // One cycle: drive, queue expectation, compare mid-cycle, advance past the edge.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic ld, input logic [4:0] rd,
                        input logic br, input logic req, input logic rdy,
                        input logic [5:0] expv, input string tag);
        logic [5:0] e;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_memRead = ld; ex_rd = rd; mem_branch_taken = br;
        mem_req = req; mem_ready = rdy;
        exp_q.push_back(expv);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, 32'(ctrl()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] expv, input string tag);
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, expv, tag);
    endtask

    initial begin
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memRead = 1'b0;
        mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        #3;
        chk("rst_ctrl", 32'(ctrl()), 32'(C_RST));
        chk("rst_cnt", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'd0);
        chk("rst_err", 32'(mem_timeout_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        idle(C_NORM, "normal");
        // load-use on rs1: exactly one bubble cycle
        step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU, "lu_rs1");
        idle(C_NORM, "lu_resume");
        chk("stall_cnt1", 32'(stall_cnt), 32'd1);

        step(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, "lu_rd0");
        step(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NORM, "lu_rs2_unused");
        step(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU, "lu_rs2");
        chk("stall_cnt2", 32'(stall_cnt), 32'd2);

        // branch beats load-use
        step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR, "br_lu");
        chk("flush_cnt1", 32'(flush_cnt), 32'd1);
        chk("stall_cnt_br", 32'(stall_cnt), 32'd2);

        // three wait cycles, branch ignored while waiting, then release
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, "wait1");
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_HOLD, "wait2_br");
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, "wait3");
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NORM, "wait_rel");
        chk("wait_cnt3", 32'(wait_cnt), 32'd3);
        chk("err_after_wait", 32'(mem_timeout_err), 32'd0);
        chk("flush_cnt_wait", 32'(flush_cnt), 32'd1);
        idle(C_NORM, "post_wait");

        // timeout: 15 wait cycles, then one drain cycle
        for (int i = 1; i <= 15; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, "to_wait");
            if (i == 14) chk("err_pre_to", 32'(mem_timeout_err), 32'd0);
        end
        chk("err_to", 32'(mem_timeout_err), 32'd1);
        idle(C_DRAIN, "drain");
        idle(C_NORM, "after_drain");
        idle(C_NORM, "after_drain2");
        chk("err_sticky", 32'(mem_timeout_err), 32'd1);
        chk("wait_sat", 32'(wait_cnt), 32'hF);

        // stall counter saturation (2 + 16 events into a 4-bit counter)
        for (int i = 0; i < 16; i++)
            step(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU, "lu_sat");
        chk("stall_sat", 32'(stall_cnt), 32'hF);
        idle(C_NORM, "post_sat");

        // asynchronous reset while in MEM_WAIT
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HOLD, "pre_rst_wait");
        #2 rst = 1'b1;
        #1;
        chk("arst_ctrl", 32'(ctrl()), 32'(C_RST));
        chk("arst_cnt", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'd0);
        chk("arst_err", 32'(mem_timeout_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, C_LU, "post_rst_run");
        chk("post_rst_stall", 32'(stall_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
